// File: rtl/pack_leb128.sv
// ---------------------------------------------------------------------------
// pack_leb128
//   Sequential LEB128 encoder. Accepts one integer per input handshake and
//   streams its unsigned or signed LEB128 encoding one byte per output
//   handshake, least-significant 7-bit group first.
//
// Parameters
//   WIDTH           significant input width, 32 or 64
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   input_a         value to encode (bits >= WIDTH replaced by extension)
//   input_a_signed  1 = signed LEB128, 0 = unsigned; sampled with input_a
//   input_a_stb     producer has a valid value
//   input_a_ack     encoder ready to accept a value
//   output_z        current encoded byte
//   output_z_stb    output_z is valid
//   output_z_ack    consumer takes the byte
//   output_z_last   current byte is the final byte of the encoding
//   output_len      byte count of the last completed encoding (1..10)
// ---------------------------------------------------------------------------
module pack_leb128 #(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] input_a,
    input  logic        input_a_signed,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [7:0]  output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack,
    output logic        output_z_last,
    output logic [3:0]  output_len
);

    localparam logic [0:0] S_GET = 1'b0;
    localparam logic [0:0] S_PUT = 1'b1;

    // Bits of input_a that carry the value; everything above is extension.
    localparam logic [63:0] VALUE_MASK = (WIDTH >= 64) ? {64{1'b1}}
                                                       : ((64'd1 << WIDTH) - 64'd1);

    logic [0:0]  r_state;
    logic [63:0] r_v;
    logic        r_sgn;
    logic [3:0]  r_n;
    logic        r_in_ack;
    logic [7:0]  r_z;
    logic        r_z_stb;
    logic        r_z_last;
    logic [3:0]  r_len;

    logic        w_accept;
    logic        w_take;
    logic        w_ext_fill;
    logic [63:0] w_ext;
    logic [63:0] w_rest;
    logic [63:0] w_next_v;
    logic        w_next_sgn;
    logic [63:0] w_next_rest;
    logic        w_next_final;

    // Shift one 7-bit group out; arithmetic for signed so the sign survives.
    function automatic logic [63:0] f_rest(input logic [63:0] v, input logic sgn);
        logic [63:0] res;
        if (sgn) begin
            res = $signed(v) >>> 7;
        end else begin
            res = v >> 7;
        end
        return res;
    endfunction

    assign w_accept   = (r_state == S_GET) && input_a_stb && r_in_ack;
    assign w_take     = (r_state == S_PUT) && output_z_ack;

    // Sign extension only for signed values; unsigned is zero extended.
    assign w_ext_fill = input_a_signed && input_a[WIDTH-1];
    assign w_ext      = (input_a & VALUE_MASK) | (w_ext_fill ? ~VALUE_MASK : 64'd0);

    assign w_rest     = f_rest(r_v, r_sgn);

    // Outputs are registered, so the byte shown next cycle is computed from
    // the value the shift register is about to hold: a freshly accepted
    // input, or the remainder after the current group.
    assign w_next_v     = w_accept ? w_ext : w_rest;
    assign w_next_sgn   = w_accept ? input_a_signed : r_sgn;
    assign w_next_rest  = f_rest(w_next_v, w_next_sgn);
    assign w_next_final = w_next_sgn
        ? (((w_next_rest == 64'd0) && !w_next_v[6]) ||
           ((w_next_rest == {64{1'b1}}) && w_next_v[6]))
        : (w_next_rest == 64'd0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_GET;
            r_v      <= 64'd0;
            r_sgn    <= 1'b0;
            r_n      <= 4'd0;
            r_in_ack <= 1'b0;
            r_z      <= 8'h00;
            r_z_stb  <= 1'b0;
            r_z_last <= 1'b0;
            r_len    <= 4'd0;
        end else begin
            case (r_state)
                S_GET: begin
                    // Ready is raised one edge after reset releases.
                    r_in_ack <= 1'b1;
                    if (w_accept) begin
                        r_v      <= w_ext;
                        r_sgn    <= input_a_signed;
                        r_n      <= 4'd0;
                        r_z      <= {!w_next_final, w_ext[6:0]};
                        r_z_last <= w_next_final;
                        r_z_stb  <= 1'b1;
                        r_in_ack <= 1'b0;
                        r_state  <= S_PUT;
                    end
                end
                S_PUT: begin
                    if (w_take) begin
                        if (r_z_last) begin
                            r_len    <= r_n + 4'd1;
                            r_z_stb  <= 1'b0;
                            r_z_last <= 1'b0;
                            r_in_ack <= 1'b1;
                            r_state  <= S_GET;
                        end else begin
                            r_v      <= w_rest;
                            r_n      <= r_n + 4'd1;
                            r_z      <= {!w_next_final, w_rest[6:0]};
                            r_z_last <= w_next_final;
                        end
                    end
                end
                default: r_state <= S_GET;
            endcase
        end
    end

    assign input_a_ack   = r_in_ack;
    assign output_z      = r_z;
    assign output_z_stb  = r_z_stb;
    assign output_z_last = r_z_last;
    assign output_len    = r_len;

endmodule

// File: doc/pack_leb128.md
# pack_leb128

Sequential LEB128 encoder: accepts one integer per transaction and streams its unsigned or signed LEB128 encoding one byte per handshake, lowest group first. It is the inverse of the core's combinational `varintN` decoder. It sits on the output side of the design, serialising stack values (i32/i64) into the byte stream used for module and result images. Handshakes use the same stb/ack convention as the FPU converters.

## Interface
- `WIDTH`, default 64: significant input width, either 32 or 64. Bits above `WIDTH` in `input_a` are ignored and replaced by the zero or sign extension of bit `WIDTH-1`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `input_a`  in  64  value to encode.
- `input_a_signed`  in  1  1 selects signed LEB128, 0 selects unsigned. Sampled together with `input_a`.
- `input_a_stb`  in  1  producer has a valid value.
- `input_a_ack`  out  1  encoder ready to accept a value.
- `output_z`  out  8  current encoded byte.
- `output_z_stb`  out  1  `output_z` is valid.
- `output_z_ack`  in  1  consumer takes the byte.
- `output_z_last`  out  1  current byte is the final byte of the encoding.
- `output_len`  out  4  number of bytes of the last completed encoding, range 1..10.

## Operation
- Two states:
  - GET: `input_a_ack`=1.
  - PUT: `output_z_stb`=1.
- All outputs are registered.
- GET→PUT on an edge where `input_a_stb`&`input_a_ack`.
  - Latch the extended value into a 64-bit shift register `v` and latch `signed`.
  - Clear byte counter `n` to 0.
- In PUT, for the current `v`:
  - `rest` = v>>7. The shift is arithmetic when signed, logical otherwise.
  - Final-byte condition, unsigned: `rest`==0.
  - Final-byte condition, signed: (`rest`==0 and v[6]==0) or (`rest`==all-ones and v[6]==1).
  - `output_z` = {!final, v[6:0]}; `output_z_last` = final.
- On an edge in PUT where `output_z_ack`=1:
  - Not final: v←`rest`, n←n+1, stay in PUT.
  - Final: `output_len`←n+1, go to GET.
- Maximum encoding length: 10 bytes for WIDTH=64, 5 bytes for WIDTH=32. No other bound check is needed.
- `input_a_stb` is ignored in PUT. No value is accepted until the encoding completes.
- `output_len` holds its value until the next completion.

## Timing
- Reset values, asserted asynchronously:
  - State GET.
  - `input_a_ack`=0 for one cycle; it rises on the first clock edge after reset deasserts.
  - `output_z_stb`=0, `output_z`=0x00, `output_z_last`=0, `output_len`=0.
- Accept edge N: `input_a_ack` falls and the first byte appears with `output_z_stb`=1 at N+1. Latency from accept to first byte is 1 cycle.
- Bytes change only on an edge where `output_z_ack`=1 and stb=1. With ack held high, one byte is transferred per cycle, with no bubbles.
- With ack low, `output_z`, `output_z_last` and `output_z_stb` stay stable indefinitely.
- On the ack edge of the final byte:
  - `output_z_stb` falls.
  - `input_a_ack`=1 from the next cycle.
- Total occupancy is 1+L cycles minimum for an L-byte encoding, including the GET cycle.
- Reset mid-encoding aborts immediately. No further bytes are emitted, and all outputs take their reset values.

## Test plan
- Unsigned 624485 (0x98765), ack always high → E5, 8E, 26 on consecutive cycles. last=1 only on 26; `output_len`=3.
- Signed cases:
  - -123456 → C0, BB, 78; len 3.
  - -1 → 7F; len 1.
  - 64 → C0, 00; len 2.
  - -64 → 40; len 1.
  - Unsigned 0 → 00; len 1.
- Maximum lengths:
  - WIDTH=64, unsigned 0xFFFFFFFFFFFFFFFF → FF×9, then 01; len 10.
  - WIDTH=32, unsigned 0xFFFFFFFF (upper `input_a` bits = 0xDEADBEEF, ignored) → FF, FF, FF, FF, 0F; len 5.
- Backpressure on 624485: drop ack for 3 cycles while 8E is shown → 8E, stb and last are unchanged; resume → 26. Pulse `input_a_stb` with a new value during PUT → ignored; the stream is unchanged.
- Back-to-back: hold `input_a_stb` with 1 and then 300 → 01 (len 1); `input_a_ack` high one cycle after its ack; then AC, 02 (len 2).
- Reset asserted between bytes 1 and 2 of 0x98765 → immediately stb=0, ack=0, len=0. After release, ack=1 after one edge. A fresh encode of 5 yields 05.
